// File: rtl/decoder_n_scan.sv
// ---------------------------------------------------------------------------
// decoder_n_scan
//   Registered N-to-2^N one-hot decoder with four operating modes:
//   direct decode, walking-one scan up, walking-one scan down and hold.
//   Scan modes hold each index for DWELL clocks and pulse `wrap` for one
//   cycle whenever a step crosses the index range boundary.
//
// Parameters
//   N      select width; Out is 2^N bits wide
//   DWELL  clocks each index is held while scanning (1..255)
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   E     in   enable; 0 clears Out, wrap and the dwell counter, Idx holds
//   mode  in   00=DIRECT 01=SCAN_UP 10=SCAN_DOWN 11=HOLD
//   load  in   load In as the current index (any mode)
//   In    in   select index (DIRECT) or start index (load)
//   Out   out  registered one-hot output, or all-zero when disabled/reset
//   Idx   out  registered current index
//   wrap  out  one-cycle pulse on a scan step across the range boundary
// ---------------------------------------------------------------------------
module decoder_n_scan #(
    parameter int N     = 3,
    parameter int DWELL = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                E,
    input  logic [1:0]          mode,
    input  logic                load,
    input  logic [N-1:0]        In,
    output logic [(1<<N)-1:0]   Out,
    output logic [N-1:0]        Idx,
    output logic                wrap
);

    localparam int W  = 1 << N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        DIRECT    = 2'b00,
        SCAN_UP   = 2'b01,
        SCAN_DOWN = 2'b10,
        HOLD      = 2'b11
    } mode_e;

    localparam logic [W-1:0]  ONE      = W'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    logic [W-1:0]  out_q, out_d;
    logic [N-1:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap_q, wrap_d;

    // NOTE: every output of this block gets a default before any branch so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        out_d  = '0;

        if (!E) begin
            // Disabled: blank the output and restart dwell on re-enable.
            cnt_d = '0;
        end else if (load || mode_e'(mode) == DIRECT) begin
            idx_d = In;
            cnt_d = '0;
            out_d = ONE << In;
        end else begin
            unique case (mode_e'(mode))
                SCAN_UP, SCAN_DOWN: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (mode_e'(mode) == SCAN_UP) begin
                            idx_d  = idx_q + N'(1);
                            wrap_d = (idx_q == '1);
                        end else begin
                            idx_d  = idx_q - N'(1);
                            wrap_d = (idx_q == '0);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    // Output follows the index being registered this edge.
                    out_d = ONE << idx_d;
                end
                HOLD: begin
                    out_d = ONE << idx_q;
                end
                default: begin
                    out_d = ONE << idx_q;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign Out  = out_q;
    assign Idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_n_scan.sv
// ---------------------------------------------------------------------------
// tb_decoder_n_scan
//   Four DUT instances: (N=3,DWELL=1), (N=3,DWELL=2), (N=3,DWELL=3) and
//   (N=4,DWELL=1). Scenarios run one instance at a time; each step drives
//   inputs, and after the edge pushes the hand-computed expected response
//   into a queue. A monitor on the falling edge pops and compares, and also
//   checks the zero-or-one-hot invariant with Out[Idx]=1.
// ---------------------------------------------------------------------------
module tb_decoder_n_scan;

    localparam logic [1:0] M_DIR  = 2'b00;
    localparam logic [1:0] M_UP   = 2'b01;
    localparam logic [1:0] M_DN   = 2'b10;
    localparam logic [1:0] M_HOLD = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v  [4];
    logic       e_v    [4];
    logic [1:0] mode_v [4];
    logic       load_v [4];
    logic [3:0] in_v   [4];

    logic [7:0]  out0, out1, out2;
    logic [15:0] out3;
    logic [2:0]  idx0, idx1, idx2;
    logic [3:0]  idx3;
    logic        wrap0, wrap1, wrap2, wrap3;

    decoder_n_scan #(.N(3), .DWELL(1)) u0 (
        .clk(clk), .rst(rst_v[0]), .E(e_v[0]), .mode(mode_v[0]), .load(load_v[0]),
        .In(in_v[0][2:0]), .Out(out0), .Idx(idx0), .wrap(wrap0));
    decoder_n_scan #(.N(3), .DWELL(2)) u1 (
        .clk(clk), .rst(rst_v[1]), .E(e_v[1]), .mode(mode_v[1]), .load(load_v[1]),
        .In(in_v[1][2:0]), .Out(out1), .Idx(idx1), .wrap(wrap1));
    decoder_n_scan #(.N(3), .DWELL(3)) u2 (
        .clk(clk), .rst(rst_v[2]), .E(e_v[2]), .mode(mode_v[2]), .load(load_v[2]),
        .In(in_v[2][2:0]), .Out(out2), .Idx(idx2), .wrap(wrap2));
    decoder_n_scan #(.N(4), .DWELL(1)) u3 (
        .clk(clk), .rst(rst_v[3]), .E(e_v[3]), .mode(mode_v[3]), .load(load_v[3]),
        .In(in_v[3]), .Out(out3), .Idx(idx3), .wrap(wrap3));

    logic [15:0] mon_out  [4];
    logic [3:0]  mon_idx  [4];
    logic        mon_wrap [4];
    assign mon_out[0] = {8'h00, out0};
    assign mon_out[1] = {8'h00, out1};
    assign mon_out[2] = {8'h00, out2};
    assign mon_out[3] = out3;
    assign mon_idx[0] = {1'b0, idx0};
    assign mon_idx[1] = {1'b0, idx1};
    assign mon_idx[2] = {1'b0, idx2};
    assign mon_idx[3] = idx3;
    assign mon_wrap[0] = wrap0;
    assign mon_wrap[1] = wrap1;
    assign mon_wrap[2] = wrap2;
    assign mon_wrap[3] = wrap3;

    typedef struct {
        int          inst;
        logic [15:0] out;
        logic [3:0]  idx;
        logic        w;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one expected entry is pushed per driven edge, popped here.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [15:0] o;
            logic [3:0]  i;
            logic        ok;
            e  = sb.pop_front();
            o  = mon_out[e.inst];
            i  = mon_idx[e.inst];
            ok = $onehot0(o) && ((o == 16'h0) || o[i]);
            check({e.name, "_out"},  32'(o), 32'(e.out));
            check({e.name, "_idx"},  32'(i), 32'(e.idx));
            check({e.name, "_wrap"}, 32'(mon_wrap[e.inst]), 32'(e.w));
            check({e.name, "_inv"},  32'(ok), 32'd1);
        end
    end

    // Drive one edge's inputs on instance `inst`, then queue what must appear.
    task automatic step(input int inst, input logic r, input logic e, input logic [1:0] m,
                        input logic ld, input logic [3:0] in, input logic [15:0] eo,
                        input logic [3:0] ei, input logic ew, input string name);
        exp_t x;
        rst_v[inst]  = r;
        e_v[inst]    = e;
        mode_v[inst] = m;
        load_v[inst] = ld;
        in_v[inst]   = in;
        @(posedge clk);
        x.inst = inst; x.out = eo; x.idx = ei; x.w = ew; x.name = name;
        sb.push_back(x);
        #1;
    endtask

    // DWELL=2 scan-up sequence from reset, hand-expanded.
    logic [7:0] up2_out [18] = '{8'h01, 8'h02, 8'h02, 8'h04, 8'h04, 8'h08, 8'h08, 8'h10,
                                 8'h10, 8'h20, 8'h20, 8'h40, 8'h40, 8'h80, 8'h80, 8'h01,
                                 8'h01, 8'h02};
    logic [2:0] up2_idx [18] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4,
                                 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 3'd0,
                                 3'd0, 3'd1};
    logic [7:0] dir_out [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst_v[k] = 1'b1; e_v[k] = 1'b0; mode_v[k] = M_DIR; load_v[k] = 1'b0; in_v[k] = 4'd0;
        end

        // --- Instance 0: N=3, DWELL=1 ---
        step(0, 1, 0, M_DIR, 0, 4'd5, 16'h0000, 4'd0, 0, "rst");
        step(0, 0, 0, M_DIR, 0, 4'd5, 16'h0000, 4'd0, 0, "disabled");
        for (int k = 0; k < 8; k++)
            step(0, 0, 1, M_DIR, 0, 4'(k), {8'h00, dir_out[k]}, 4'(k), 0, $sformatf("direct%0d", k));
        step(0, 0, 0, M_DIR, 0, 4'd3, 16'h0000, 4'd7, 0, "dis_hold_idx");
        step(0, 0, 1, M_DN, 1, 4'd2, 16'h0004, 4'd2, 0, "load2");
        step(0, 0, 1, M_DN, 0, 4'd5, 16'h0002, 4'd1, 0, "dn_a");
        step(0, 0, 1, M_DN, 0, 4'd5, 16'h0001, 4'd0, 0, "dn_b");
        step(0, 0, 1, M_DN, 0, 4'd5, 16'h0080, 4'd7, 1, "dn_wrap");
        step(0, 0, 1, M_DN, 0, 4'd5, 16'h0040, 4'd6, 0, "dn_c");
        step(0, 0, 1, M_UP, 0, 4'd0, 16'h0080, 4'd7, 0, "up_a");
        step(0, 0, 1, M_UP, 0, 4'd0, 16'h0001, 4'd0, 1, "up_wrap");
        step(0, 1, 1, M_UP, 1, 4'd6, 16'h0000, 4'd0, 0, "rst_prio");
        step(0, 0, 1, M_UP, 1, 4'd6, 16'h0040, 4'd6, 0, "load6");

        // --- Instance 1: N=3, DWELL=2 ---
        step(1, 1, 0, M_DIR, 0, 4'd0, 16'h0000, 4'd0, 0, "rst1");
        for (int k = 0; k < 18; k++)
            step(1, 0, 1, M_UP, 0, 4'd0, {8'h00, up2_out[k]}, {1'b0, up2_idx[k]},
                 (k == 15), $sformatf("up2_%0d", k));

        // --- Instance 2: N=3, DWELL=3 ---
        step(2, 1, 0, M_DIR, 0, 4'd0, 16'h0000, 4'd0, 0, "rst2");
        step(2, 0, 1, M_UP, 0, 4'd0, 16'h0001, 4'd0, 0, "up3_a");
        step(2, 0, 1, M_UP, 0, 4'd0, 16'h0001, 4'd0, 0, "up3_b");
        step(2, 0, 1, M_UP, 0, 4'd0, 16'h0002, 4'd1, 0, "up3_step");
        step(2, 0, 1, M_UP, 0, 4'd0, 16'h0002, 4'd1, 0, "up3_cnt1");
        for (int k = 0; k < 4; k++)
            step(2, 0, 1, M_HOLD, 0, 4'd5, 16'h0002, 4'd1, 0, $sformatf("hold%0d", k));
        step(2, 0, 1, M_UP, 0, 4'd0, 16'h0002, 4'd1, 0, "resume_cnt2");
        step(2, 0, 1, M_UP, 0, 4'd0, 16'h0004, 4'd2, 0, "resume_step");
        step(2, 0, 0, M_UP, 0, 4'd0, 16'h0000, 4'd2, 0, "dis3");
        step(2, 0, 1, M_UP, 0, 4'd0, 16'h0004, 4'd2, 0, "reen_a");
        step(2, 0, 1, M_UP, 0, 4'd0, 16'h0004, 4'd2, 0, "reen_b");
        step(2, 0, 1, M_UP, 0, 4'd0, 16'h0008, 4'd3, 0, "reen_step");
        step(2, 0, 1, M_UP, 0, 4'd0, 16'h0008, 4'd3, 0, "sw_up");
        step(2, 0, 1, M_DN, 0, 4'd0, 16'h0008, 4'd3, 0, "sw_dn_keep");
        step(2, 0, 1, M_DN, 0, 4'd0, 16'h0004, 4'd2, 0, "sw_dn_step");

        // --- Instance 3: N=4, DWELL=1 ---
        step(3, 1, 0, M_DIR, 0, 4'd0, 16'h0000, 4'd0, 0, "rst4");
        step(3, 0, 1, M_DIR, 0, 4'd15, 16'h8000, 4'd15, 0, "n4_direct15");
        step(3, 0, 1, M_DIR, 0, 4'd0, 16'h0001, 4'd0, 0, "n4_direct0");
        step(3, 0, 1, M_DN, 0, 4'd9, 16'h8000, 4'd15, 1, "n4_dn_wrap");

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
